// File: rtl/mypkg.sv
// Shared types and constants for the trace dispatcher: address split widths,
// trace command encoding, FSM states and the queued record layout.
package mypkg;
  localparam int ADDR_W      = 32;
  localparam int CMD_W       = 4;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 14;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [CMD_W-1:0] {
    RD_L1    = 4'd0,
    WR_L1    = 4'd1,
    RD_INST  = 4'd2,
    SNP_INV  = 4'd3,
    SNP_RD   = 4'd4,
    SNP_WR   = 4'd5,
    SNP_RWIM = 4'd6,
    CLEAR    = 4'd8,
    PRINT    = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [CMD_W-1:0]       cmd;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
    logic                   snoop;
    logic                   ctrl;
  } rec_t;

  function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
    return (c <= SNP_RWIM) || (c == CLEAR) || (c == PRINT);
  endfunction

  function automatic logic cmd_snoop(input logic [CMD_W-1:0] c);
    return (c >= SNP_INV) && (c <= SNP_RWIM);
  endfunction

  function automatic logic cmd_ctrl(input logic [CMD_W-1:0] c);
    return (c == CLEAR) || (c == PRINT);
  endfunction
endpackage

// File: rtl/trace_dispatch_if.sv
// Trace-reader input and cache-controller output handshakes of trace_dispatch.
interface trace_dispatch_if;
  import mypkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [CMD_W-1:0]       in_cmd;
  logic [ADDR_W-1:0]      in_addr;
  logic                   in_eof;
  logic                   out_valid;
  logic                   out_ready;
  logic [CMD_W-1:0]       out_cmd;
  logic [TAG_BITS-1:0]    out_tag;
  logic [INDEX_BITS-1:0]  out_index;
  logic [OFFSET_BITS-1:0] out_offset;
  logic                   out_snoop;
  logic                   out_ctrl;

  modport master (
    output in_valid, in_cmd, in_addr, in_eof, out_ready,
    input  in_ready, out_valid, out_cmd, out_tag, out_index, out_offset,
           out_snoop, out_ctrl
  );

  modport slave (
    input  in_valid, in_cmd, in_addr, in_eof, out_ready,
    output in_ready, out_valid, out_cmd, out_tag, out_index, out_offset,
           out_snoop, out_ctrl
  );
endinterface

// File: rtl/address_parse.sv
// Splits a trace address into cache tag / index / offset fields.
module address_parse
  import mypkg::*;
(
  input  logic [ADDR_W-1:0]      addr,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] offset
);
  assign offset = addr[OFFSET_BITS-1:0];
  assign index  = addr[OFFSET_BITS +: INDEX_BITS];
  assign tag    = addr[ADDR_W-1 -: TAG_BITS];
endmodule

// File: rtl/trace_dispatch.sv
// Queues decoded trace records for the cache controller, drops illegal
// commands with a count, and reports completion once EOF has fully drained.
module trace_dispatch
  import mypkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  trace_dispatch_if.slave  bus,
  output logic             done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] dispatched_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_e                 state_q, state_d;
  rec_t                   mem [DEPTH];
  rec_t                   head;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   live_q;
  logic                   hs_in, push, drop, pop, legal;
  logic [TAG_BITS-1:0]    p_tag;
  logic [INDEX_BITS-1:0]  p_index;
  logic [OFFSET_BITS-1:0] p_offset;

  address_parse u_parse (
    .addr   (bus.in_addr),
    .tag    (p_tag),
    .index  (p_index),
    .offset (p_offset)
  );

  // live_q holds in_ready low through reset and the first edge after it
  assign bus.in_ready  = live_q && (state_q == RUN) && (count != FULL_CNT);
  assign bus.out_valid = (count != '0);
  assign legal = cmd_legal(bus.in_cmd);
  assign hs_in = bus.in_valid && bus.in_ready;
  assign push  = hs_in && legal;
  assign drop  = hs_in && !legal;
  assign pop   = bus.out_valid && bus.out_ready;
  assign done  = (state_q == DONE);

  // Head fields forced to zero when empty so reset and idle present clean zeros
  assign head           = mem[rd_ptr];
  assign bus.out_cmd    = bus.out_valid ? head.cmd    : '0;
  assign bus.out_tag    = bus.out_valid ? head.tag    : '0;
  assign bus.out_index  = bus.out_valid ? head.index  : '0;
  assign bus.out_offset = bus.out_valid ? head.offset : '0;
  assign bus.out_snoop  = bus.out_valid ? head.snoop  : 1'b0;
  assign bus.out_ctrl   = bus.out_valid ? head.ctrl   : 1'b0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.in_eof && !hs_in) state_d = DRAIN;
      DRAIN:   if (count == '0)          state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      live_q         <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_pulse      <= 1'b0;
      dispatched_cnt <= '0;
      err_cnt        <= '0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      err_pulse <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && (dispatched_cnt != '1)) dispatched_cnt <= dispatched_cnt + 1'b1;
      if (drop && (err_cnt != '1))       err_cnt <= err_cnt + 1'b1;
    end
  end

  // Storage carries no reset; out_valid gating hides stale entries
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd:    bus.in_cmd,
                               tag:    p_tag,
                               index:  p_index,
                               offset: p_offset,
                               snoop:  cmd_snoop(bus.in_cmd),
                               ctrl:   cmd_ctrl(bus.in_cmd)};
  end
endmodule

// File: tb/tb_trace_dispatch.sv
// Self-checking bench for trace_dispatch: table-driven records through a
// scoreboard plus directed backpressure, illegal-command, EOF and reset cases.
module tb_trace_dispatch;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] tag;
    logic [13:0] idx;
    logic [5:0]  off;
    logic        snoop;
    logic        ctrl;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    bit          legal;
    exp_t        e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done, err_pulse;
  logic [3:0] dispatched_cnt, err_cnt;

  trace_dispatch_if bus ();

  trace_dispatch #(.DEPTH(4), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .done           (done),
    .err_pulse      (err_pulse),
    .dispatched_cnt (dispatched_cnt),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [3:0] exp_disp = '0;
  int   exp_err  = 0;
  int   seen_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t exp_of(input logic [3:0] c, input logic [31:0] a);
    exp_t e;
    e.cmd   = c;
    e.off   = a[5:0];
    e.idx   = a[19:6];
    e.tag   = a[31:20];
    e.snoop = (c >= 4'd3) && (c <= 4'd6);
    e.ctrl  = (c == 4'd8) || (c == 4'd9);
    return e;
  endfunction

  // Pops are judged half a cycle before the edge that performs them
  always @(negedge clk) begin
    if (!rst && err_pulse) seen_err++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'(bus.out_cmd), 32'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_cmd",    32'(bus.out_cmd),    32'(e.cmd));
        chk("pop_tag",    32'(bus.out_tag),    32'(e.tag));
        chk("pop_index",  32'(bus.out_index),  32'(e.idx));
        chk("pop_offset", 32'(bus.out_offset), 32'(e.off));
        chk("pop_snoop",  32'(bus.out_snoop),  32'(e.snoop));
        chk("pop_ctrl",   32'(bus.out_ctrl),   32'(e.ctrl));
        if (exp_disp != 4'hF) exp_disp = exp_disp + 4'd1;
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input exp_t e, input bit legal);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_addr  = a;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      k++;
      if (k > 40) begin
        chk("send_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (legal) sb.push_back(e);
    else exp_err++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (bus.out_valid && k < 60);
    chk("drain_timeout", 32'(bus.out_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    exp_disp = '0;
    exp_err  = 0;
    seen_err = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    logic [3:0]  h_cmd;
    logic [11:0] h_tag;
    logic [13:0] h_idx;
    logic [5:0]  h_off;

    tbl[0]  = '{4'd0,  32'h12345678, 1'b1, '{4'd0, 12'h123, 14'h1159, 6'h38, 1'b0, 1'b0}};
    tbl[1]  = '{4'd4,  32'hFFFFFFFF, 1'b1, '{4'd4, 12'hFFF, 14'h3FFF, 6'h3F, 1'b1, 1'b0}};
    tbl[2]  = '{4'd9,  32'h00000000, 1'b1, '{4'd9, 12'h000, 14'h0000, 6'h00, 1'b0, 1'b1}};
    tbl[3]  = '{4'd7,  32'hDEADBEEF, 1'b0, '{4'd7, 12'h000, 14'h0000, 6'h00, 1'b0, 1'b0}};
    tbl[4]  = '{4'd2,  32'h00000040, 1'b1, '{4'd2, 12'h000, 14'h0001, 6'h00, 1'b0, 1'b0}};
    tbl[5]  = '{4'd3,  32'h00100000, 1'b1, '{4'd3, 12'h001, 14'h0000, 6'h00, 1'b1, 1'b0}};
    tbl[6]  = '{4'd8,  32'h000FFFC1, 1'b1, '{4'd8, 12'h000, 14'h3FFF, 6'h01, 1'b0, 1'b1}};
    tbl[7]  = '{4'd6,  32'h80000020, 1'b1, '{4'd6, 12'h800, 14'h0000, 6'h20, 1'b1, 1'b0}};
    tbl[8]  = '{4'd15, 32'h00000001, 1'b0, '{4'hF, 12'h000, 14'h0000, 6'h00, 1'b0, 1'b0}};
    tbl[9]  = '{4'd5,  32'h0ABCDE3F, 1'b1, '{4'd5, 12'h0AB, 14'h3378, 6'h3F, 1'b1, 1'b0}};
    tbl[10] = '{4'd1,  32'h00000FFF, 1'b1, '{4'd1, 12'h000, 14'h003F, 6'h3F, 1'b0, 1'b0}};

    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_addr = '0;
    bus.in_eof = 1'b0;   bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_done",      32'(done),          32'd0);
    chk("rst_err_pulse", 32'(err_pulse),     32'd0);
    chk("rst_out_cmd",   32'(bus.out_cmd),   32'd0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    chk("rst_disp_cnt",  32'(dispatched_cnt), 32'd0);
    chk("rst_err_cnt",   32'(err_cnt),       32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Table phase, free-flowing output
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].cmd, tbl[i].addr, tbl[i].e, tbl[i].legal);
      if (i == 0) begin
        chk("single_latency_valid", 32'(bus.out_valid), 32'd1);
        chk("single_cmd",           32'(bus.out_cmd),   32'd0);
        @(posedge clk); #1;
        chk("single_disp_cnt",      32'(dispatched_cnt), 32'd1);
      end
    end
    wait_drain();
    chk("tbl_disp_cnt", 32'(dispatched_cnt), 32'(exp_disp));
    chk("tbl_err_cnt",  32'(err_cnt),        32'(exp_err));
    chk("tbl_err_seen", 32'(seen_err),       32'(exp_err));

    // Backpressure: fill to full, hold, then release while a 5th waits
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(4'(i), 32'h1000 * i + i, exp_of(4'(i), 32'h1000 * i + i), 1'b1);
    chk("full_in_ready", 32'(bus.in_ready),  32'd0);
    chk("full_valid",    32'(bus.out_valid), 32'd1);
    h_cmd = bus.out_cmd; h_tag = bus.out_tag; h_idx = bus.out_index; h_off = bus.out_offset;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_cmd",    32'(bus.out_cmd),    32'(h_cmd));
    chk("stall_tag",    32'(bus.out_tag),    32'(h_tag));
    chk("stall_index",  32'(bus.out_index),  32'(h_idx));
    chk("stall_offset", 32'(bus.out_offset), 32'(h_off));
    fork
      send(4'd5, 32'h0000_5005, exp_of(4'd5, 32'h0000_5005), 1'b1);
      begin
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_no_comb_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("full_pop_ready_next", 32'(bus.in_ready), 32'd1);
      end
    join
    wait_drain();
    chk("bp_disp_cnt", 32'(dispatched_cnt), 32'(exp_disp));

    // Illegal command followed by a legal one
    send(4'd7, 32'hDEADBEEF, exp_of(4'd7, 32'hDEADBEEF), 1'b0);
    chk("illegal_pulse_hi", 32'(err_pulse), 32'd1);
    send(4'd2, 32'h0000_0040, exp_of(4'd2, 32'h0000_0040), 1'b1);
    chk("illegal_pulse_lo", 32'(err_pulse), 32'd0);
    wait_drain();
    chk("illegal_err_cnt",  32'(err_cnt),        32'(exp_err));
    chk("illegal_err_seen", 32'(seen_err),       32'(exp_err));
    chk("illegal_disp_cnt", 32'(dispatched_cnt), 32'(exp_disp));

    // EOF: last record handshakes with eof high, then drain to DONE
    bus.out_ready = 1'b0;
    send(4'd0, 32'h0000_1111, exp_of(4'd0, 32'h0000_1111), 1'b1);
    send(4'd1, 32'h0000_2222, exp_of(4'd1, 32'h0000_2222), 1'b1);
    bus.in_eof = 1'b1;
    send(4'd3, 32'h0000_3333, exp_of(4'd3, 32'h0000_3333), 1'b1);
    chk("eof_hs_stays_run", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
    chk("drain_done_e1",  32'(done),         32'd0);
    @(posedge clk); #1;
    chk("drain_done_e2",  32'(done),         32'd0);
    @(posedge clk); #1;
    chk("drain_empty",    32'(bus.out_valid), 32'd0);
    chk("drain_done_e3",  32'(done),          32'd0);
    @(posedge clk); #1;
    chk("done_set",       32'(done),          32'd1);
    bus.in_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky",    32'(done),           32'd1);
    chk("done_in_ready",  32'(bus.in_ready),   32'd0);
    chk("disp_saturated", 32'(dispatched_cnt), 32'hF);
    chk("sb_after_drain", 32'(sb.size()),      32'd0);

    // Reset out of DONE, then snoop/ctrl flags
    do_reset();
    chk("rst2_done",     32'(done),           32'd0);
    chk("rst2_in_ready", 32'(bus.in_ready),   32'd0);
    chk("rst2_disp_cnt", 32'(dispatched_cnt), 32'd0);
    chk("rst2_err_cnt",  32'(err_cnt),        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst2_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    send(4'd4, 32'h0000_0100, exp_of(4'd4, 32'h0000_0100), 1'b1);
    send(4'd9, 32'h0000_0200, exp_of(4'd9, 32'h0000_0200), 1'b1);
    chk("snoop_head_cmd",  32'(bus.out_cmd),   32'd4);
    chk("snoop_head_snp",  32'(bus.out_snoop), 32'd1);
    chk("snoop_head_ctrl", 32'(bus.out_ctrl),  32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ctrl_head_snp",  32'(bus.out_snoop), 32'd0);
    chk("ctrl_head_ctrl", 32'(bus.out_ctrl),  32'd1);
    wait_drain();

    // Reset mid-stream with two records queued
    bus.out_ready = 1'b0;
    send(4'd1, 32'h0000_0A00, exp_of(4'd1, 32'h0000_0A00), 1'b1);
    send(4'd5, 32'h0000_0B00, exp_of(4'd5, 32'h0000_0B00), 1'b1);
    chk("mid_queued", 32'(bus.out_valid), 32'd1);
    @(negedge clk); #2;
    do_reset();
    chk("mid_valid_async", 32'(bus.out_valid),   32'd0);
    chk("mid_disp_cnt",    32'(dispatched_cnt),  32'd0);
    chk("mid_err_cnt",     32'(err_cnt),         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_dispatch", 32'(bus.out_valid),  32'd0);
    chk("mid_disp_after",  32'(dispatched_cnt), 32'd0);
    chk("mid_run_ready",   32'(bus.in_ready),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
